// File: rtl/issue_ack_pkg.sv
// Shared types and default sizes for the issue/acknowledge arbiter.
package issue_ack_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int CNT_W_DEF = 8;

  // IDLE waits for a request, ISSUE drives the one-cycle strobe and
  // CHECK samples the acknowledge that must follow it.
  typedef enum logic [1:0] {
    IA_IDLE  = 2'd0,
    IA_ISSUE = 2'd1,
    IA_CHECK = 2'd2
  } ia_state_e;

endpackage

// File: rtl/issue_ack_arbiter_if.sv
// Bundle of requester/responder signals around the issue/ack arbiter.
// master: requesters + responder side, slave: the arbiter itself.
interface issue_ack_arbiter_if
  import issue_ack_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]  req;
  logic             ack;
  logic             clr_err;
  logic             b;
  logic [IDX_W-1:0] issue_id;
  logic [NREQ-1:0]  gnt;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_seen;
  logic             busy;

  modport master (
    output req, ack, clr_err,
    input  b, issue_id, gnt, done, err, err_cnt, err_seen, busy
  );

  modport slave (
    input  req, ack, clr_err,
    output b, issue_id, gnt, done, err, err_cnt, err_seen, busy
  );

endinterface

// File: rtl/issue_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from (last+1) mod NREQ upward
// and returns the first active requester.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  // cand[k] is the requester visited at search distance k+1 from last_i.
  logic [IDX_W-1:0] cand [NREQ];
  logic [NREQ-1:0]  hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    localparam int OFFS = gi + 1;
    assign cand[gi] = IDX_W'((int'(last_i) + OFFS) % NREQ);
    assign hit[gi]  = req_i[cand[gi]];
  end

  // Scan farthest-first so the nearest active candidate overrides the rest.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner_o = cand[k];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_ack_arbiter.sv
// Round-robin owner of a shared issue/ack resource. Issues a one-cycle `b`
// strobe for the winner, expects `ack` in the following cycle and reports a
// grant or a protocol error. Define ISSUE_ACK_SVA_EN to compile in the
// protocol assertions and the back-to-back cover.
module issue_ack_arbiter
  import issue_ack_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  issue_ack_arbiter_if.slave bus
);

  localparam int               IDX_W   = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  ia_state_e        state_q,    state_d;
  logic [IDX_W-1:0] last_q,     last_d;
  logic [IDX_W-1:0] owner_q,    owner_d;
  logic             b_q,        b_d;
  logic [IDX_W-1:0] issue_id_q, issue_id_d;
  logic [NREQ-1:0]  gnt_q,      gnt_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic             err_seen_q, err_seen_d;
  logic             busy_q,     busy_d;

  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;

  // In CHECK the current owner becomes "last" this very cycle, so the
  // back-to-back decision must already rotate past it.
  assign pick_last = (state_q == IA_CHECK) ? owner_q : last_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (bus.req),
    .last_i   (pick_last),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  // Next-state and registered-output decode; every pulse defaults low.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    b_d        = 1'b0;
    issue_id_d = '0;
    gnt_d      = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_seen_d = err_seen_q;

    case (state_q)
      IA_IDLE: begin
        if (pick_valid) begin
          state_d    = IA_ISSUE;
          owner_d    = pick_winner;
          b_d        = 1'b1;
          issue_id_d = pick_winner;
        end
      end
      IA_ISSUE: begin
        state_d = IA_CHECK;
      end
      IA_CHECK: begin
        last_d = owner_q;
        if (bus.ack) begin
          gnt_d[owner_q] = 1'b1;
          done_d         = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        if (pick_valid) begin
          state_d    = IA_ISSUE;
          owner_d    = pick_winner;
          b_d        = 1'b1;
          issue_id_d = pick_winner;
        end else begin
          state_d = IA_IDLE;
        end
      end
      default: begin
        state_d = IA_IDLE;
      end
    endcase

    // A clear in the same cycle as a new error still records that error.
    if (bus.clr_err) begin
      err_cnt_d  = err_d ? CNT_W'(1) : '0;
      err_seen_d = err_d;
    end else if (err_d) begin
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      err_seen_d = 1'b1;
    end

    busy_d = (state_d != IA_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IA_IDLE;
      last_q     <= LAST_RST;
      owner_q    <= '0;
      b_q        <= 1'b0;
      issue_id_q <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      b_q        <= b_d;
      issue_id_q <= issue_id_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_seen_q <= err_seen_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.b        = b_q;
  assign bus.issue_id = issue_id_q;
  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.err_seen = err_seen_q;
  assign bus.busy     = busy_q;

`ifdef ISSUE_ACK_SVA_EN
  // Responder must acknowledge exactly one cycle after each issue strobe.
  a_b_then_ack: assert property (@(posedge clk) disable iff (rst) b_q |=> bus.ack);
  // At most one requester is granted per cycle.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  // The strobe is a single-cycle pulse; back-to-back issues are two apart.
  a_b_pulse: assert property (@(posedge clk) disable iff (rst) b_q |=> !b_q);
  // Back-to-back: completion of one transaction alongside the next issue.
  c_back_to_back: cover property (@(posedge clk) disable iff (rst) b_q && done_q);
`endif

endmodule

// File: tb/tb_issue_ack_arbiter.sv
// Self-checking bench for issue_ack_arbiter: directed scenarios plus a
// randomized run against a cycle-numbered transaction model.
module tb_issue_ack_arbiter;
  import issue_ack_pkg::*;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_ack_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();
  issue_ack_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: a transaction is identified by the cycle its strobe appears in.
  int       cyc = 0;
  int       m_issue_at = -10;
  int       m_owner = 0;
  int       m_last = NREQ - 1;
  bit       e_b, e_done, e_err, e_seen, e_busy;
  int       e_id, e_cnt;
  bit [3:0] e_gnt;
  bit       e_b_prev, e_b_prev2;

  // Drive one cycle of inputs, predict the next cycle's outputs, advance.
  task automatic tick(input logic [3:0] r, input logic a, input logic c, input logic rs);
    bit issuing, checking, decide;
    int w;
    bus.req = r; bus.ack = a; bus.clr_err = c; rst = rs;
    issuing  = (m_issue_at == cyc);
    checking = (m_issue_at == cyc - 1);
    e_b_prev2 = e_b_prev;
    e_b_prev  = e_b;
    if (rs) begin
      e_b = 0; e_id = 0; e_gnt = 0; e_done = 0; e_err = 0; e_cnt = 0; e_seen = 0; e_busy = 0;
      m_last = NREQ - 1; m_issue_at = -10;
    end else begin
      e_b = 0; e_id = 0; e_gnt = 0; e_done = 0; e_err = 0;
      if (checking) begin
        if (a) begin e_gnt = 4'(1 << m_owner); e_done = 1; end
        else e_err = 1;
        m_last = m_owner;
      end
      if (c) begin
        e_cnt = e_err ? 1 : 0; e_seen = e_err;
      end else if (e_err) begin
        if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
        e_seen = 1;
      end
      decide = 0;
      if (!issuing && r != 0) begin
        for (int k = 1; k <= NREQ && !decide; k++) begin
          w = (m_last + k) % NREQ;
          if (r[w]) begin decide = 1; m_owner = w; end
        end
      end
      if (decide) begin e_b = 1; e_id = m_owner; m_issue_at = cyc + 1; end
      e_busy = issuing || decide;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Let any outstanding work finish with well-behaved acks.
  task automatic drain();
    for (int i = 0; i < 8 && e_busy; i++) tick(4'b0000, e_b_prev, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL drain_idle busy=%0b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.b, bus.issue_id, bus.gnt, bus.done, bus.err, bus.err_cnt, bus.err_seen, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs b=%0b id=%0d gnt=%b done=%0b err=%0b cnt=%0d seen=%0b busy=%0b expected all 0",
               bus.b, bus.issue_id, bus.gnt, bus.done, bus.err, bus.err_cnt, bus.err_seen, bus.busy);
    end
    tick(4'b0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_ack_ignored err=%0b busy=%0b expected 0 0", bus.err, bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.b !== 1'b1 || bus.issue_id !== 2'd2) begin
      errors++; $display("FAIL single_issue b=%0b id=%0d expected 1 2", bus.b, bus.issue_id);
    end
    tick(4'b0100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.b !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_check b=%0b busy=%0b expected 0 1", bus.b, bus.busy);
    end
    tick(4'b0100, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.gnt !== 4'b0100 || bus.done !== 1'b1 || bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL single_grant gnt=%b done=%0b err=%0b cnt=%0d expected 0100 1 0 0",
               bus.gnt, bus.done, bus.err, bus.err_cnt);
    end
    drain();
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int n = 0;
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      tick(4'b1111, e_b_prev, 1'b0, 1'b0);
      if (i >= 2 && i % 2 == 0) begin
        checks++;
        if (bus.gnt !== 4'(1 << (n % 4)) || bus.b !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant_%0d gnt=%b b=%0b expected %b 1", n, bus.gnt, bus.b, 4'(1 << (n % 4)));
        end
        n++;
      end else begin
        checks++;
        if (bus.gnt !== 4'b0000) begin
          errors++; $display("FAIL rr_gap_%0d gnt=%b expected 0000", i, bus.gnt);
        end
      end
    end
    drain();
    $display("test_round_robin done");
  endtask

  task automatic test_no_ack();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0001, 1'b0, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.err_seen !== 1'b1 || bus.gnt !== 4'b0000 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL no_ack_err err=%0b cnt=%0d seen=%0b gnt=%b done=%0b expected 1 1 1 0000 0",
               bus.err, bus.err_cnt, bus.err_seen, bus.gnt, bus.done);
    end
    checks++;
    if (bus.b !== 1'b1 || bus.issue_id !== 2'd0) begin
      errors++; $display("FAIL no_ack_retry b=%0b id=%0d expected 1 0", bus.b, bus.issue_id);
    end
    drain();
    $display("test_no_ack done");
  endtask

  task automatic test_late_ack();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0001, 1'b0, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL late_ack_err err=%0b cnt=%0d busy=%0b expected 1 1 0", bus.err, bus.err_cnt, bus.busy);
    end
    tick(4'b0000, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b0 || bus.gnt !== 4'b0000 || bus.err_cnt !== 8'd1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored err=%0b gnt=%b cnt=%0d done=%0b expected 0 0000 1 0",
               bus.err, bus.gnt, bus.err_cnt, bus.done);
    end
    $display("test_late_ack done");
  endtask

  task automatic test_saturation();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 620; i++) tick(4'b0001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.err_cnt !== 8'd255 || bus.err_seen !== 1'b1) begin
      errors++; $display("FAIL sat_count cnt=%0d seen=%0b expected 255 1", bus.err_cnt, bus.err_seen);
    end
    for (int i = 0; i < 4 && !e_b_prev; i++) tick(4'b0001, 1'b0, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1 || bus.err_seen !== 1'b1) begin
      errors++; $display("FAIL clr_with_err err=%0b cnt=%0d seen=%0b expected 1 1 1", bus.err, bus.err_cnt, bus.err_seen);
    end
    tick(4'b0001, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.err_cnt !== 8'd0 || bus.err_seen !== 1'b0) begin
      errors++; $display("FAIL clr_plain cnt=%0d seen=%0b expected 0 0", bus.err_cnt, bus.err_seen);
    end
    drain();
    $display("test_saturation done");
  endtask

  task automatic test_rst_mid();
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b1000, 1'b0, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0, 1'b0);
    tick(4'b1000, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({bus.b, bus.issue_id, bus.gnt, bus.done, bus.err, bus.err_cnt, bus.err_seen, bus.busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs b=%0b gnt=%b done=%0b err=%0b busy=%0b expected all 0",
               bus.b, bus.gnt, bus.done, bus.err, bus.busy);
    end
    tick(4'b1001, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.b !== 1'b1 || bus.issue_id !== 2'd0) begin
      errors++; $display("FAIL rst_mid_first b=%0b id=%0d expected 1 0", bus.b, bus.issue_id);
    end
    drain();
    $display("test_rst_mid done");
  endtask

  task automatic test_random();
    logic [3:0] hold = 4'b0000;
    logic       a, c, rs;
    int         bad;
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NREQ; k++) if ($urandom_range(0, 3) == 0) hold[k] = 1'b1;
      if ($urandom_range(0, 29) == 0) hold[$urandom_range(0, NREQ - 1)] = 1'b0;
      a  = ($urandom_range(0, 9) < 7) ? e_b_prev : (($urandom_range(0, 1) == 1) ? e_b_prev2 : 1'($urandom_range(0, 1)));
      c  = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 149) == 0);
      tick(hold, a, c, rs);
      hold = hold & ~e_gnt;
      bad = 0;
      checks++;
      if (bus.b !== e_b || bus.issue_id !== 2'(e_id) || bus.gnt !== e_gnt || bus.done !== e_done ||
          bus.err !== e_err || bus.err_cnt !== 8'(e_cnt) || bus.err_seen !== e_seen || bus.busy !== e_busy) begin
        errors++;
        $display("FAIL rand_cycle_%0d got b=%0b id=%0d gnt=%b done=%0b err=%0b cnt=%0d seen=%0b busy=%0b exp b=%0b id=%0d gnt=%b done=%0b err=%0b cnt=%0d seen=%0b busy=%0b",
                 i, bus.b, bus.issue_id, bus.gnt, bus.done, bus.err, bus.err_cnt, bus.err_seen, bus.busy,
                 e_b, e_id, e_gnt, e_done, e_err, e_cnt, e_seen, e_busy);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    bus.req = '0; bus.ack = 1'b0; bus.clr_err = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_ack();
    test_late_ack();
    test_saturation();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
